shifter_arbiter: RTL and testbench

Registered arbiter and sequencer that shares one `right_logic_shifter` instance among `NREQ` requesters. Each requester presents an operand and a shift amount with a valid/ready handshake. The block grants requesters round-robin, captures the winning operands, runs the shift, and holds the result on a response port until it is accepted. It sits between ALU-level clients and the logical right-shift datapath.

---
 rtl/shift_ctrl_pkg.sv | 13 +
 rtl/right_logic_shifter.sv | 13 +
 rtl/rr_picker.sv | 34 +++
 rtl/shifter_arbiter.sv | 110 +++++++++++
 tb/tb_shifter_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared state type and ID-width helper for the shifter arbiter
package shift_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} shift_ctrl_state_t;

  localparam int MIN_ID_W = 1;

  // A single requester still needs a one-bit ID field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : MIN_ID_W;
  endfunction

endpackage

// File: rtl/right_logic_shifter.sv
// rtl/right_logic_shifter.sv - combinational logical right shift, zero fill
module right_logic_shifter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] shift,
  output logic [WIDTH-1:0] y
);

  // Shift amounts of WIDTH or more naturally produce zero.
  assign y = a >> shift;

endmodule

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin priority picker, search starts at ptr and wraps
module rr_picker import shift_ctrl_pkg::*; #(
  parameter int NREQ = 2,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
    for (int j = 0; j < NREQ; j++) begin
      if (!any && req[j] && (j >= int'(ptr))) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!any && req[j] && (j < int'(ptr))) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - round-robin arbiter sharing one right_logic_shifter among NREQ requesters
module shifter_arbiter import shift_ctrl_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  parameter int IDW   = id_width(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_shift,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH-1:0]            rsp_y,
  output logic [IDW-1:0]              rsp_id
);

  shift_ctrl_state_t state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [WIDTH-1:0]  rsp_y_q, rsp_y_d;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              any;
  logic [WIDTH-1:0]  shift_y;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  right_logic_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .a     (a_q),
    .shift (sh_q),
    .y     (shift_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      sh_q     <= '0;
      rsp_y_q  <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      sh_q     <= sh_d;
      rsp_y_q  <= rsp_y_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    sh_d      = sh_q;
    rsp_y_d   = rsp_y_q;
    rsp_id_d  = rsp_id_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        // The state register already reads IDLE under reset, so gate grants explicitly.
        if (any && !rst) begin
          req_ready = grant;
          a_d       = req_a[grant_idx];
          sh_d      = req_shift[grant_idx];
          id_d      = grant_idx;
          rr_ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_y_d  = shift_y;
        rsp_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb/tb_shifter_arbiter.sv - self-checking bench for shifter_arbiter with a transaction-level model
module tb_shifter_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_shift;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [WIDTH-1:0]           rsp_y;
  logic [IDW-1:0]             rsp_id;

  int checks   = 0;
  int failures = 0;

  // Model: an operation's age in cycles since acceptance (-1 = none in flight).
  int m_age = -1;
  int m_ptr = 0;
  int m_y   = 0;
  int m_id  = 0;
  int acc_cnt [NREQ];
  int seen    [NREQ];

  always #5 clk = ~clk;

  shifter_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_shift (req_shift),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id)
  );

  function automatic int shr(input int a, input int s);
    return (s >= WIDTH) ? 0 : a / (1 << s);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: checks every cycle, then advances the model across the coming edge.
  initial begin : compare
    int g;
    int idx;
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_y", int'(rsp_y), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        m_age = -1;
        m_ptr = 0;
      end else begin
        g = -1;
        if (m_age < 0) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
        chk("rsp_valid", int'(rsp_valid), (m_age >= 2) ? 1 : 0);
        if (m_age >= 2) begin
          chk("rsp_y", int'(rsp_y), m_y);
          chk("rsp_id", int'(rsp_id), m_id);
        end
        if (g >= 0) begin
          m_y   = shr(int'(req_a[g]), int'(req_shift[g]));
          m_id  = g;
          m_ptr = (g + 1) % NREQ;
          m_age = 1;
          acc_cnt[g] = acc_cnt[g] + 1;
        end else if (m_age == 1) begin
          m_age = 2;
        end else if (m_age >= 2 && rsp_ready) begin
          m_age = -1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (seen[i] != acc_cnt[i]) begin
        seen[i] = acc_cnt[i];
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic present(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] s);
    req_valid[i] = 1'b1;
    req_a[i]     = a;
    req_shift[i] = s;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int ey, input int eid);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      #2;
      if (rsp_valid) got = 1'b1;
    end
    chk({name, "_seen"}, int'(got), 1);
    if (got) begin
      chk({name, "_y"}, int'(rsp_y), ey);
      chk({name, "_id"}, int'(rsp_id), eid);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [WIDTH-1:0] b_a [4];
    logic [WIDTH-1:0] b_s [4];
    int               b_e [4];
    b_a = '{4'b1111, 4'b1111, 4'b1011, 4'b1001};
    b_s = '{4'd4,    4'd0,    4'd3,    4'd15};
    b_e = '{0,       15,      1,       0};

    for (int i = 0; i < NREQ; i++) seen[i] = 0;
    rst       = 1'b1;
    req_valid = 2'b11;
    req_a     = '{4'b0101, 4'b0011};
    req_shift = '{4'd1, 4'd2};
    rsp_ready = 1'b1;
    repeat (3) begin
      tick();
      #2;
      chk("reset_hold_ready", int'(req_ready), 0);
    end
    tick();
    rst       = 1'b0;
    req_valid = '0;

    // Single request
    tick();
    present(0, 4'b1100, 4'd1);
    #2;
    chk("single_grant", int'(req_ready), 1);
    tick();
    tick();
    #2;
    chk("single_rsp_valid", int'(rsp_valid), 1);
    chk("single_rsp_y", int'(rsp_y), 6);
    chk("single_rsp_id", int'(rsp_id), 0);

    // Round robin from a fresh pointer, then again after the wrap
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      present(0, 4'b1010, 4'd2);
      present(1, 4'b1111, 4'd1);
      wait_rsp("rr_first", 2, 0);
      wait_rsp("rr_second", 7, 1);
    end

    // Backpressure with req1 waiting
    tick();
    rsp_ready = 1'b0;
    present(0, 4'b0110, 4'd1);
    wait_rsp("bp", 3, 0);
    present(1, 4'b1000, 4'd2);
    repeat (5) begin
      tick();
      #2;
      chk("bp_hold_valid", int'(rsp_valid), 1);
      chk("bp_hold_y", int'(rsp_y), 3);
      chk("bp_hold_id", int'(rsp_id), 0);
      chk("bp_hold_ready", int'(req_ready), 0);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    #2;
    chk("bp_grant_req1", int'(req_ready), 2);
    wait_rsp("bp_req1", 2, 1);

    // Shift boundaries
    for (int b = 0; b < 4; b++) begin
      tick();
      present(0, b_a[b], b_s[b]);
      wait_rsp("boundary", b_e[b], 0);
    end

    // Reset during EXEC aborts the operation
    tick();
    present(0, 4'b1101, 4'd1);
    tick();
    rst = 1'b1;
    #2;
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      #2;
      chk("abort_no_rsp", int'(rsp_valid), 0);
    end
    tick();
    present(0, 4'b0011, 4'd1);
    present(1, 4'b1100, 4'd2);
    #2;
    chk("post_reset_grant", int'(req_ready), 1);
    wait_rsp("post_rst0", 1, 0);
    wait_rsp("post_rst1", 3, 1);

    // Randomized traffic, backpressure and occasional reset pulses
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick();
      rst = ($urandom_range(0, 99) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          present(i, WIDTH'($urandom), WIDTH'($urandom_range(0, 15)));
        end
      end
    end
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
